iexecute: RTL and testbench
===========================

Name: iexecute

Overview:
- Execute stage of the 5-stage LEGv8 pipeline.
- Sits between decode and the data-memory stage.
- Registers its decode-side inputs (ID/EX register), then computes:
  - ALU result and zero flag,
  - branch target,
  - an iterative 64-bit MUL that stalls the front end.
- Forwards all memory and writeback controls to the memory stage.

Parameters:
- WORD, 64 (= `WORD from definitions.vh): datapath width.
- MUL_OPC, 11'b10011011000: opcode that selects the multi-cycle multiplier.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush_in  in  1  squash the instruction being captured, or abort an in-flight MUL
- cur_pc_in  in  WORD  PC of the instruction
- read_data1_in, read_data2_in  in  WORD  register-file operands
- sign_extend_imm_in  in  WORD  sign-extended immediate / branch offset
- shamt_in  in  6  shift amount for LSL/LSR
- opcode_in  in  11  instruction opcode
- alu_op_in  in  2  00 add, 01 pass B, 10 R/I-type by opcode
- alu_src_in  in  1  B operand: 0 = read_data2, 1 = immediate
- branch_in, uncondbranch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in  in  1 each  controls
- write_register_in  in  5  destination register
- stall  out  1  hold fetch/decode and the ID/EX inputs
- zero, branch, uncondbranch, mem_read, mem_write, mem_to_reg, reg_write  out  1 each
- mem_address  out  WORD  ALU or multiplier result
- mem_write_data  out  WORD  registered read_data2
- branch_target  out  WORD  cur_pc + (imm << 2)
- cur_pc  out  WORD
- opcode  out  11
- write_register  out  5

Behaviour:
- Reset (asynchronous, active-high rst):
  - all ID/EX registers cleared; state = IDLE; stall = 0.
  - every output is 0, which is a bubble.
- Capture:
  - At each posedge with stall = 0, the ID/EX register loads all *_in values.
  - If flush_in = 1 at that edge, all control bits load as 0 (bubble); data fields are don't-care.
- Datapath (combinational from the ID/EX register, 0 added latency):
  - B = alu_src ? imm : read_data2.
  - alu_op 00: A + B.
  - alu_op 01: B (used by CBZ).
  - alu_op 10, by opcode:
    - ADD/ADDI → A + B; SUB/SUBI → A − B.
    - AND → A & B; ORR → A | B.
    - LSL → A << shamt; LSR → A >> shamt (logical).
    - Unknown opcode → 0.
  - Arithmetic wraps modulo 2^WORD.
  - zero = (result == 0).
  - branch_target = cur_pc + (imm << 2), truncated to WORD.
- States:
  - IDLE:
    - Normal single-cycle operation; outputs follow the ID/EX register.
    - If the captured opcode == MUL_OPC and it is not flushed, go to MUL_RUN.
  - MUL_RUN:
    - stall = 1; all control outputs forced to 0 (bubble to the memory stage).
    - Shift-add, one multiplier bit per edge: acc += mcand when mplier[0]; mcand <<= 1; mplier >>= 1; cnt++.
    - Exactly WORD edges, no early exit; after the edge where cnt == WORD−1, go to MUL_DONE.
  - MUL_DONE:
    - stall = 0; outputs present the captured MUL controls.
    - mem_address = low WORD bits of A×B; zero = (product == 0).
    - Next edge: capture the next instruction and return to IDLE, or re-enter MUL_RUN on back-to-back MUL.
- Stall timing: a MUL holds stall high for exactly WORD cycles. The memory stage sees WORD bubbles and then the product.
- Boundaries:
  - flush_in during MUL_RUN: abort, acc discarded, go to IDLE with a bubble loaded, stall low from the next cycle.
  - flush_in and a MUL capture on the same edge: bubble; no MUL started.
  - rst mid-MUL: immediate return to IDLE with all outputs 0.
  - MUL with an operand of 0: still WORD cycles; result 0, zero = 1.

Decomposition:
- Package exec_pkg:
  - opcode constants (ADD, SUB, AND, ORR, ADDI, SUBI, LSL, LSR, MUL, LDUR, STUR, CBZ, B),
  - alu_op enum,
  - state enum {IDLE, MUL_RUN, MUL_DONE}.
- One sub-module: seq_multiplier.
  - Inputs: clk, rst, start, abort, a, b.
  - Outputs: busy, done, product.
  - Owns acc, mcand, mplier and cnt.
- ALU stays inline in iexecute.

Test Plan:
- Reset asserted mid-run → all outputs 0 asynchronously, stall = 0.
- ADD: read_data1 = 5, read_data2 = 7, alu_op 10, opcode ADD → mem_address = 12 and zero = 0 in the cycle after capture; reg_write = 1.
- SUB 9−9 → mem_address = 0, zero = 1.
- CBZ: read_data2 = 0, alu_op 01, imm = 4, cur_pc = 0x100 → zero = 1, branch = 1, branch_target = 0x110.
- MUL: 3 × 0xFFFFFFFFFFFFFFFF → stall high exactly 64 cycles with reg_write = 0 throughout; then mem_address = 0xFFFFFFFFFFFFFFFD, reg_write = 1, stall = 0.
- MUL, flush_in pulsed on cycle 10 of MUL_RUN → stall drops the next cycle, reg_write stays 0, the next ADD executes normally.
- STUR: read_data1 = 0x40, imm = 8, read_data2 = 0xAB → mem_address = 0x48, mem_write_data = 0xAB, mem_write = 1, reg_write = 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the LEGv8 execute stage: opcodes, ALU control
// encodings, FSM states and the ALU function decoder.
package exec_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_PASSB = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_LSL, FN_LSR, FN_PASSB, FN_ZERO
  } alu_fn_e;

  // I-type opcodes are only 10 bits wide; bit 0 of the field belongs to the immediate.
  function automatic alu_fn_e decode_fn(input alu_op_e alu_op, input logic [10:0] opc);
    alu_fn_e fn;
    fn = FN_ZERO;
    case (alu_op)
      ALU_ADD:   fn = FN_ADD;
      ALU_PASSB: fn = FN_PASSB;
      ALU_RTYPE: begin
        casez (opc)
          OP_ADD, 11'b1001000100?: fn = FN_ADD;
          OP_SUB, 11'b1101000100?: fn = FN_SUB;
          OP_AND:                  fn = FN_AND;
          OP_ORR:                  fn = FN_ORR;
          OP_LSL:                  fn = FN_LSL;
          OP_LSR:                  fn = FN_LSR;
          default:                 fn = FN_ZERO;
        endcase
      end
      default:   fn = FN_ZERO;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/iexecute_if.sv
// Decode-side inputs and memory-stage outputs of the execute stage.
interface iexecute_if #(parameter int WORD = 64);

  logic            flush_in;
  logic [WORD-1:0] cur_pc_in;
  logic [WORD-1:0] read_data1_in;
  logic [WORD-1:0] read_data2_in;
  logic [WORD-1:0] sign_extend_imm_in;
  logic [5:0]      shamt_in;
  logic [10:0]     opcode_in;
  logic [1:0]      alu_op_in;
  logic            alu_src_in;
  logic            branch_in;
  logic            uncondbranch_in;
  logic            mem_read_in;
  logic            mem_write_in;
  logic            mem_to_reg_in;
  logic            reg_write_in;
  logic [4:0]      write_register_in;

  logic            stall;
  logic            zero;
  logic            branch;
  logic            uncondbranch;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic            reg_write;
  logic [WORD-1:0] mem_address;
  logic [WORD-1:0] mem_write_data;
  logic [WORD-1:0] branch_target;
  logic [WORD-1:0] cur_pc;
  logic [10:0]     opcode;
  logic [4:0]      write_register;

  modport master (
    output flush_in, cur_pc_in, read_data1_in, read_data2_in, sign_extend_imm_in,
           shamt_in, opcode_in, alu_op_in, alu_src_in, branch_in, uncondbranch_in,
           mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, write_register_in,
    input  stall, zero, branch, uncondbranch, mem_read, mem_write, mem_to_reg,
           reg_write, mem_address, mem_write_data, branch_target, cur_pc, opcode,
           write_register
  );

  modport slave (
    input  flush_in, cur_pc_in, read_data1_in, read_data2_in, sign_extend_imm_in,
           shamt_in, opcode_in, alu_op_in, alu_src_in, branch_in, uncondbranch_in,
           mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, write_register_in,
    output stall, zero, branch, uncondbranch, mem_read, mem_write, mem_to_reg,
           reg_write, mem_address, mem_write_data, branch_target, cur_pc, opcode,
           write_register
  );

endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier retiring one multiplier bit per clock; always WORD steps.
module seq_multiplier #(
  parameter int WORD = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] product
);

  localparam int CW = $clog2(WORD);

  logic [WORD-1:0] acc;
  logic [WORD-1:0] mcand;
  logic [WORD-1:0] mplier;
  logic [CW-1:0]   cnt;

  // done flags the final step: product is complete right after this edge.
  assign done    = busy && (cnt == CW'(WORD - 1));
  assign product = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      acc  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/iexecute.sv
// LEGv8 execute stage: ID/EX register, inline ALU, branch target adder and
// a multi-cycle MUL that stalls the front end while it iterates.
module iexecute
  import exec_pkg::*;
#(
  parameter int          WORD    = 64,
  parameter logic [10:0] MUL_OPC = 11'b10011011000
) (
  input  logic clk,
  input  logic rst,
  iexecute_if.slave ex
);

  state_e          state;
  logic            stall_q;

  logic [WORD-1:0] cur_pc_p0;
  logic [WORD-1:0] rd1_p0;
  logic [WORD-1:0] rd2_p0;
  logic [WORD-1:0] imm_p0;
  logic [5:0]      shamt_p0;
  logic [10:0]     opcode_p0;
  logic [1:0]      alu_op_p0;
  logic            alu_src_p0;
  logic [5:0]      ctl_p0;
  logic [4:0]      wr_p0;
  logic            vld_p0;

  logic            mul_in;
  logic            mul_start;
  logic            mul_abort;
  logic            mul_busy;
  logic            mul_done;
  logic [WORD-1:0] mul_product;
  logic [WORD-1:0] b_in;

  assign b_in      = ex.alu_src_in ? ex.sign_extend_imm_in : ex.read_data2_in;
  assign mul_in    = (ex.opcode_in == MUL_OPC) && !ex.flush_in;
  assign mul_start = !stall_q && mul_in;
  assign mul_abort = (state == MUL_RUN) && ex.flush_in;

  seq_multiplier #(.WORD(WORD)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (ex.read_data1_in),
    .b       (b_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // ---- ID/EX register and MUL sequencing ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      stall_q    <= 1'b0;
      cur_pc_p0  <= '0;
      rd1_p0     <= '0;
      rd2_p0     <= '0;
      imm_p0     <= '0;
      shamt_p0   <= '0;
      opcode_p0  <= '0;
      alu_op_p0  <= '0;
      alu_src_p0 <= 1'b0;
      ctl_p0     <= '0;
      wr_p0      <= '0;
      vld_p0     <= 1'b0;
    end else begin
      case (state)
        IDLE, MUL_DONE: begin
          cur_pc_p0  <= ex.cur_pc_in;
          rd1_p0     <= ex.read_data1_in;
          rd2_p0     <= ex.read_data2_in;
          imm_p0     <= ex.sign_extend_imm_in;
          shamt_p0   <= ex.shamt_in;
          opcode_p0  <= ex.opcode_in;
          alu_op_p0  <= ex.alu_op_in;
          alu_src_p0 <= ex.alu_src_in;
          wr_p0      <= ex.write_register_in;
          vld_p0     <= !ex.flush_in;
          ctl_p0     <= ex.flush_in ? 6'b0 :
                        {ex.branch_in, ex.uncondbranch_in, ex.mem_read_in,
                         ex.mem_write_in, ex.mem_to_reg_in, ex.reg_write_in};
          state      <= mul_in ? MUL_RUN : IDLE;
          stall_q    <= mul_in;
        end
        MUL_RUN: begin
          if (ex.flush_in) begin
            ctl_p0  <= '0;
            vld_p0  <= 1'b0;
            state   <= IDLE;
            stall_q <= 1'b0;
          end else if (mul_done || !mul_busy) begin
            state   <= MUL_DONE;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // ---- combinational execute from the ID/EX register ----
  logic [WORD-1:0] b_p0;
  logic [WORD-1:0] alu_res;
  logic [WORD-1:0] result;
  logic            in_run;

  assign b_p0 = alu_src_p0 ? imm_p0 : rd2_p0;

  always_comb begin
    alu_res = '0;
    case (decode_fn(alu_op_e'(alu_op_p0), opcode_p0))
      FN_ADD:   alu_res = rd1_p0 + b_p0;
      FN_SUB:   alu_res = rd1_p0 - b_p0;
      FN_AND:   alu_res = rd1_p0 & b_p0;
      FN_ORR:   alu_res = rd1_p0 | b_p0;
      FN_LSL:   alu_res = rd1_p0 << shamt_p0;
      FN_LSR:   alu_res = rd1_p0 >> shamt_p0;
      FN_PASSB: alu_res = b_p0;
      default:  alu_res = '0;
    endcase
  end

  assign in_run = (state == MUL_RUN);
  assign result = (state == MUL_DONE) ? mul_product : alu_res;

  // Bubbles (reset, flushed slots, MUL iterations) never report zero.
  assign ex.zero           = vld_p0 && !in_run && (result == '0);
  assign ex.mem_address    = result;
  assign ex.mem_write_data = rd2_p0;
  assign ex.branch_target  = cur_pc_p0 + {imm_p0[WORD-3:0], 2'b00};
  assign ex.cur_pc         = cur_pc_p0;
  assign ex.opcode         = opcode_p0;
  assign ex.write_register = wr_p0;
  assign ex.stall          = stall_q;

  assign {ex.branch, ex.uncondbranch, ex.mem_read,
          ex.mem_write, ex.mem_to_reg, ex.reg_write} = in_run ? 6'b0 : ctl_p0;

endmodule

// File: tb/tb_iexecute.sv
// Directed bench for the execute stage: ALU ops, CBZ/STUR, multi-cycle MUL,
// flush and reset boundary cases.
module tb_iexecute;
  import exec_pkg::*;

  localparam logic [5:0] CTL_NONE = 6'b000000;
  localparam logic [5:0] CTL_RW   = 6'b000001;
  localparam logic [5:0] CTL_STUR = 6'b000100;
  localparam logic [5:0] CTL_CBZ  = 6'b100000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  iexecute_if #(.WORD(64)) bus ();

  iexecute #(.WORD(64), .MUL_OPC(11'b10011011000)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [10:0] opc, input logic [1:0] aop, input logic src,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                       input logic [5:0] sh, input logic [63:0] pc, input logic [5:0] ctl,
                       input logic [4:0] wr);
    bus.opcode_in          = opc;
    bus.alu_op_in          = aop;
    bus.alu_src_in         = src;
    bus.read_data1_in      = a;
    bus.read_data2_in      = b;
    bus.sign_extend_imm_in = imm;
    bus.shamt_in           = sh;
    bus.cur_pc_in          = pc;
    bus.write_register_in  = wr;
    {bus.branch_in, bus.uncondbranch_in, bus.mem_read_in,
     bus.mem_write_in, bus.mem_to_reg_in, bus.reg_write_in} = ctl;
  endtask

  task automatic nop();
    drive(11'd0, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0, 6'd0, 64'd0, CTL_NONE, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive stalled cycles from the current sample point.
  task automatic wait_mul(output int cycles, output logic rw_seen);
    cycles  = 0;
    rw_seen = 1'b0;
    while (bus.stall && cycles < 200) begin
      cycles++;
      rw_seen = rw_seen | bus.reg_write;
      step();
    end
  endtask

  typedef struct {
    logic [10:0] opc;
    logic        src;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  sh;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [9];
  int   cyc;
  logic rws;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{OP_AND,  1'b0, 64'hF0F0, 64'hFF00, 6'd0,  64'hF000};
    vecs[1] = '{OP_ORR,  1'b0, 64'hF0,   64'h0F,   6'd0,  64'hFF};
    vecs[2] = '{OP_LSL,  1'b0, 64'd1,    64'd0,    6'd63, 64'h8000_0000_0000_0000};
    vecs[3] = '{OP_LSR,  1'b0, 64'h8000_0000_0000_0000, 64'd0, 6'd4, 64'h0800_0000_0000_0000};
    vecs[4] = '{OP_ADDI, 1'b1, 64'd100,  64'd23,   6'd0,  64'd123};
    vecs[5] = '{11'b10010001001, 1'b1, 64'd1, 64'd2, 6'd0, 64'd3};
    vecs[6] = '{OP_SUBI, 1'b1, 64'd10,   64'd3,    6'd0,  64'd7};
    vecs[7] = '{OP_ADD,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 64'd0};
    vecs[8] = '{OP_LDUR, 1'b0, 64'd5,    64'd6,    6'd0,  64'd0};

    rst = 1'b1;
    bus.flush_in = 1'b0;
    nop();
    #12;
    expect_eq("rst_stall", 64'(bus.stall), 64'd0);
    expect_eq("rst_regwrite", 64'(bus.reg_write), 64'd0);
    expect_eq("rst_zero", 64'(bus.zero), 64'd0);
    expect_eq("rst_addr", bus.mem_address, 64'd0);
    rst = 1'b0;

    drive(OP_ADD, 2'b10, 1'b0, 64'd5, 64'd7, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd3);
    step();
    expect_eq("add_addr", bus.mem_address, 64'd12);
    expect_eq("add_zero", 64'(bus.zero), 64'd0);
    expect_eq("add_rw", 64'(bus.reg_write), 64'd1);
    expect_eq("add_wr", 64'(bus.write_register), 64'd3);

    drive(OP_SUB, 2'b10, 1'b0, 64'd9, 64'd9, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd4);
    step();
    expect_eq("sub_addr", bus.mem_address, 64'd0);
    expect_eq("sub_zero", 64'(bus.zero), 64'd1);

    drive(OP_CBZ, 2'b01, 1'b0, 64'h55, 64'd0, 64'd4, 6'd0, 64'h100, CTL_CBZ, 5'd0);
    step();
    expect_eq("cbz_zero", 64'(bus.zero), 64'd1);
    expect_eq("cbz_branch", 64'(bus.branch), 64'd1);
    expect_eq("cbz_target", bus.branch_target, 64'h110);
    expect_eq("cbz_rw", 64'(bus.reg_write), 64'd0);

    drive(OP_STUR, 2'b00, 1'b1, 64'h40, 64'hAB, 64'd8, 6'd0, 64'h0, CTL_STUR, 5'd0);
    step();
    expect_eq("stur_addr", bus.mem_address, 64'h48);
    expect_eq("stur_wdata", bus.mem_write_data, 64'hAB);
    expect_eq("stur_mw", 64'(bus.mem_write), 64'd1);
    expect_eq("stur_rw", 64'(bus.reg_write), 64'd0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].opc, 2'b10, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].b,
            vecs[i].sh, 64'd0, CTL_RW, 5'd1);
      step();
      expect_eq($sformatf("alu%0d", i), bus.mem_address, vecs[i].exp);
    end

    // Flushed capture is a bubble even when the result would be zero.
    bus.flush_in = 1'b1;
    drive(OP_SUB, 2'b10, 1'b0, 64'd9, 64'd9, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd4);
    step();
    expect_eq("flush_rw", 64'(bus.reg_write), 64'd0);
    expect_eq("flush_zero", 64'(bus.zero), 64'd0);
    drive(OP_MUL, 2'b10, 1'b0, 64'd3, 64'd4, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd2);
    step();
    expect_eq("flushmul_stall", 64'(bus.stall), 64'd0);
    bus.flush_in = 1'b0;
    nop();
    step();
    expect_eq("flushmul_stall2", 64'(bus.stall), 64'd0);

    // Back-to-back MULs: 3 * (2^64-1) then 7 * 6.
    drive(OP_MUL, 2'b10, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd7);
    step();
    drive(OP_MUL, 2'b10, 1'b0, 64'd7, 64'd6, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd8);
    wait_mul(cyc, rws);
    expect_eq("mul1_cycles", 64'(cyc), 64'd64);
    expect_eq("mul1_rw_run", 64'(rws), 64'd0);
    expect_eq("mul1_addr", bus.mem_address, 64'hFFFF_FFFF_FFFF_FFFD);
    expect_eq("mul1_rw", 64'(bus.reg_write), 64'd1);
    expect_eq("mul1_stall", 64'(bus.stall), 64'd0);
    expect_eq("mul1_wr", 64'(bus.write_register), 64'd7);
    step();
    expect_eq("mul2_stall", 64'(bus.stall), 64'd1);
    nop();
    wait_mul(cyc, rws);
    expect_eq("mul2_cycles", 64'(cyc), 64'd64);
    expect_eq("mul2_addr", bus.mem_address, 64'd42);
    expect_eq("mul2_zero", 64'(bus.zero), 64'd0);
    step();
    expect_eq("after_mul_stall", 64'(bus.stall), 64'd0);

    // Zero operand still takes the full iteration count.
    drive(OP_MUL, 2'b10, 1'b0, 64'd0, 64'd5, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd9);
    step();
    nop();
    wait_mul(cyc, rws);
    expect_eq("mul0_cycles", 64'(cyc), 64'd64);
    expect_eq("mul0_addr", bus.mem_address, 64'd0);
    expect_eq("mul0_zero", 64'(bus.zero), 64'd1);
    step();

    // Flush on the tenth MUL_RUN cycle aborts the multiply.
    drive(OP_MUL, 2'b10, 1'b0, 64'd9, 64'd9, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd10);
    step();
    nop();
    repeat (9) step();
    expect_eq("abort_pre_stall", 64'(bus.stall), 64'd1);
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    expect_eq("abort_stall", 64'(bus.stall), 64'd0);
    expect_eq("abort_rw", 64'(bus.reg_write), 64'd0);
    expect_eq("abort_zero", 64'(bus.zero), 64'd0);
    drive(OP_ADD, 2'b10, 1'b0, 64'd5, 64'd7, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd3);
    step();
    expect_eq("abort_add", bus.mem_address, 64'd12);
    expect_eq("abort_add_rw", 64'(bus.reg_write), 64'd1);
    expect_eq("abort_add_stall", 64'(bus.stall), 64'd0);

    // Asynchronous reset in the middle of a MUL.
    drive(OP_MUL, 2'b10, 1'b0, 64'd3, 64'd3, 64'd4, 6'd0, 64'h200, CTL_RW, 5'd11);
    step();
    nop();
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    expect_eq("rstmid_stall", 64'(bus.stall), 64'd0);
    expect_eq("rstmid_rw", 64'(bus.reg_write), 64'd0);
    expect_eq("rstmid_addr", bus.mem_address, 64'd0);
    expect_eq("rstmid_target", bus.branch_target, 64'd0);
    expect_eq("rstmid_pc", bus.cur_pc, 64'd0);
    expect_eq("rstmid_opcode", 64'(bus.opcode), 64'd0);
    expect_eq("rstmid_zero", 64'(bus.zero), 64'd0);
    rst = 1'b0;
    drive(OP_ORR, 2'b10, 1'b0, 64'h100, 64'h001, 64'd0, 6'd0, 64'd0, CTL_RW, 5'd5);
    step();
    expect_eq("post_rst_orr", bus.mem_address, 64'h101);
    expect_eq("post_rst_stall", 64'(bus.stall), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
